evp_horner_engine: RTL and testbench
====================================

# evp_horner_engine

Parametrised polynomial-evaluation engine for the EVP instruction path. On `start` it reads the degree N of coefficient set `a_sel` from the N-memory, streams coefficients c_N..c_0 from the S-memory and evaluates p(x) = Σ c_i·x^i by Horner's rule. It returns a result word and a status word with a one-cycle `done` pulse. It generalises the fixed-width EVP FSM with configurable data width, accumulator width, set count and maximum degree, signed arithmetic, overflow detection and a degree-range check.

## Interface
- DATA_W, 16, width of x and of each coefficient (signed two's complement)
- ACC_W, 32, width of accumulator and `result` (signed)
- NUM_SETS, 8, number of coefficient sets; SEL_W = clog2(NUM_SETS)
- MAX_DEG, 10, largest legal degree; each set occupies MAX_DEG+1 S-memory words
- SADDR_W, 7, S-memory address width; must satisfy 2^SADDR_W ≥ NUM_SETS·(MAX_DEG+1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when `busy`=0
- a_sel  in  SEL_W  coefficient-set select, sampled with accepted `start`
- x  in  DATA_W  evaluation point, sampled with accepted `start`
- busy  out  1  high from the cycle after acceptance through the `done` cycle
- n_rd_en  out  1  N-memory read strobe
- n_rd_addr  out  SEL_W  N-memory address (= latched a_sel)
- n_rd_data  in  5  degree; valid the cycle after `n_rd_en`
- s_rd_en  out  1  S-memory read strobe
- s_rd_addr  out  SADDR_W  = a_sel·(MAX_DEG+1) + idx; c_0 lives at offset 0
- s_rd_data  in  DATA_W  coefficient; valid the cycle after `s_rd_en`
- done  out  1  one-cycle completion pulse
- result  out  ACC_W  p(x) modulo 2^ACC_W; 0 on error
- status  out  32  0 ok, 1 overflow, 2 N unprogrammed (0x1F), 3 N > MAX_DEG

## Operation
- States: IDLE, RD_N, CHK_N, RD_C, MAC, FIN, ERR.
- IDLE: on `start`, latch a_sel and x, go to RD_N. With `start`=0, stay in IDLE.
- RD_N: `n_rd_en`=1. Next state is CHK_N.
- CHK_N: if n_rd_data==5'h1F, go to ERR with code 2. Else if n_rd_data>MAX_DEG, go to ERR with code 3. Else latch idx=N, clear the overflow flag and the first flag, and go to RD_C.
- RD_C: `s_rd_en`=1 at the current idx. Next state is MAC.
- MAC: on the first coefficient, acc = sign-extended s_rd_data. Otherwise acc = acc·x + s_rd_data, using full-precision signed product (ACC_W+DATA_W bits) and sum, then truncated to ACC_W.
- Overflow: the sticky overflow flag sets if the product or the sum does not fit in signed ACC_W.
- MAC exit: if idx==0, go to FIN. Else decrement idx and go to RD_C.
- FIN: `done`=1, result=acc, status = overflow ? 1 : 0. Next state is IDLE.
- ERR: `done`=1, result=0, status=code. Next state is IDLE.
- `result`/`status` hold their values until the next FIN/ERR. They are not cleared on `start`.
- `start` while `busy`=1 is ignored, with no queueing.
- Strobes (`n_rd_en`, `s_rd_en`, `done`) are low in every state not listed above.

## Timing
- Reset (rst=1 at a clock edge) forces IDLE. Reset values: busy=0, done=0, n_rd_en=0, s_rd_en=0, n_rd_addr=0, s_rd_addr=0, result=0, status=32'hFFFF_FFFF.
- Reset mid-operation aborts the evaluation with no `done` pulse. rst has priority over `start` in the same cycle.
- All outputs are registered or decoded from registered state. `done` is registered and coincides with the update of `result`/`status`.
- Cycle numbering: start accepted at cycle 0; RD_N at 1; CHK_N at 2; RD_C/MAC pairs at 3..2N+4; FIN (`done`) at cycle 2N+5.
- Error path: ERR (`done`) at cycle 3.
- Back-to-back: `start` is accepted in the cycle after FIN/ERR, since the FSM is back in IDLE then.
- Memories are synchronous with 1-cycle read latency. The engine never issues a read whose data it does not consume.

## Test plan
- Set 2: N=2, c0=3, c1=2, c2=1, x=4 -> `done` at cycle 9 with result=27, status=0. s_rd_addr sequence 24, 23, 22.
- Set 0: N=0, c0=-5, x=7 -> `done` at cycle 5 with result=-5 (32'hFFFF_FFFB), status=0. Exactly one S read.
- Set 1: n_rd_data=5'h1F -> `done` at cycle 3 with result=0, status=2, no `s_rd_en`. Repeat with N=11 -> status=3.
- ACC_W=32: N=3, all c=16'h7FFF, x=16'h7FFF -> status=1, result = low 32 bits of the exact value. A following N=1, c=[1,1], x=1 run -> status=0, result=2 (overflow flag cleared).
- Assert `start` with a_sel=3 during a busy run -> ignored; a_sel/x of the running job unchanged and single `done`. `start` on the cycle after `done` -> accepted.
- Assert rst at cycle 5 of an N=4 run -> no `done`; outputs at reset values next cycle. A new `start` then completes normally.

Source files
------------

// File: rtl/evp_horner_engine.sv
// ---------------------------------------------------------------------------
// evp_horner_engine
//
// Evaluates p(x) = sum c_i * x^i by Horner's rule for one of NUM_SETS
// coefficient sets. The degree N of the selected set comes from a small
// N-memory. Coefficients c_N..c_0 are then streamed from the S-memory.
// Both memories are external and synchronous, with a 1-cycle read latency.
//
// Handshake: `start` is a request that is accepted only in a cycle where
// `busy` is low. `a_sel` and `x` are captured in that same cycle. `busy` then
// stays high through the `done` cycle. Any `start` seen while `busy` is high
// is dropped; it is not queued. `done` is a single-cycle pulse, and
// `result`/`status` change only in that cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, a_sel, x       request, coefficient-set select, evaluation point
//   busy                  engine is working on an accepted request
//   n_rd_en/_addr/_data   N-memory read port (degree, 5'h1F = unprogrammed)
//   s_rd_en/_addr/_data   S-memory read port (coefficients, c_0 at offset 0)
//   done, result, status  completion pulse, p(x) mod 2^ACC_W, status code
//                         (0 ok, 1 overflow, 2 N unprogrammed, 3 N > MAX_DEG)
//   dbg_state             current FSM state, for observation only
// ---------------------------------------------------------------------------
module evp_horner_engine #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int NUM_SETS = 8,
    parameter int MAX_DEG  = 10,
    parameter int SADDR_W  = 7,
    localparam int SEL_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SEL_W-1:0]   a_sel,
    input  logic [DATA_W-1:0]  x,
    output logic               busy,
    output logic               n_rd_en,
    output logic [SEL_W-1:0]   n_rd_addr,
    input  logic [4:0]         n_rd_data,
    output logic               s_rd_en,
    output logic [SADDR_W-1:0] s_rd_addr,
    input  logic [DATA_W-1:0]  s_rd_data,
    output logic               done,
    output logic [ACC_W-1:0]   result,
    output logic [31:0]        status,
    output logic [2:0]         dbg_state
);

    localparam int PROD_W = ACC_W + DATA_W;
    localparam logic [4:0]         MAX_DEG_L  = 5'(MAX_DEG);
    localparam logic [SADDR_W-1:0] SET_STRIDE = SADDR_W'(MAX_DEG + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_N  = 3'd1,
        S_CHK_N = 3'd2,
        S_RD_C  = 3'd3,
        S_MAC   = 3'd4,
        S_FIN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [SEL_W-1:0]         sel_q;
    logic signed [DATA_W-1:0] x_q;
    logic [4:0]               idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     ovf_q;
    logic                     first_q;
    logic [ACC_W-1:0]         result_q;
    logic [31:0]              status_q;
    logic                     done_q;

    // Degree check performed in CHK_N.
    logic        n_err;
    logic [31:0] err_code;

    always_comb begin
        n_err    = 1'b0;
        err_code = 32'd0;
        if (n_rd_data == 5'h1F) begin
            n_err    = 1'b1;
            err_code = 32'd2;
        end else if (n_rd_data > MAX_DEG_L) begin
            n_err    = 1'b1;
            err_code = 32'd3;
        end
    end

    // Horner step at full precision. The 48-bit intermediate cannot wrap:
    // |acc*x| <= 2^46, and adding one coefficient keeps it well in range.
    logic signed [PROD_W-1:0] prod_w;
    logic signed [PROD_W-1:0] coef_w;
    logic signed [PROD_W-1:0] sum_w;
    logic [DATA_W:0]          prod_top;
    logic [DATA_W:0]          sum_top;
    logic signed [ACC_W-1:0]  mac_acc;
    logic                     mac_ovf;

    always_comb begin
        prod_w   = $signed(acc_q) * $signed(x_q);
        coef_w   = $signed(s_rd_data);
        sum_w    = prod_w + coef_w;
        // A value fits in signed ACC_W when every bit from the ACC_W-1
        // sign position upward matches.
        prod_top = prod_w[PROD_W-1:ACC_W-1];
        sum_top  = sum_w[PROD_W-1:ACC_W-1];
        if (first_q) begin
            mac_acc = coef_w[ACC_W-1:0];
            mac_ovf = 1'b0;
        end else begin
            mac_acc = sum_w[ACC_W-1:0];
            mac_ovf = !((&prod_top) || !(|prod_top)) ||
                      !((&sum_top)  || !(|sum_top));
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RD_N;
            S_RD_N:  state_d = S_CHK_N;
            S_CHK_N: state_d = n_err ? S_ERR : S_RD_C;
            S_RD_C:  state_d = S_MAC;
            S_MAC:   state_d = (idx_q == 5'd0) ? S_FIN : S_RD_C;
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs decoded from registered state.
    always_comb begin
        busy      = (state_q != S_IDLE);
        n_rd_en   = (state_q == S_RD_N);
        s_rd_en   = (state_q == S_RD_C);
        dbg_state = state_q;
    end

    // Datapath registers. The result/status are written on the edge that
    // enters FIN/ERR, so they become visible in the same cycle as `done`.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            x_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
            result_q <= '0;
            status_q <= '1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q <= a_sel;
                        x_q   <= x;
                    end
                end
                S_CHK_N: begin
                    if (n_err) begin
                        result_q <= '0;
                        status_q <= err_code;
                        done_q   <= 1'b1;
                    end else begin
                        idx_q   <= n_rd_data;
                        ovf_q   <= 1'b0;
                        first_q <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q   <= mac_acc;
                    ovf_q   <= ovf_q | mac_ovf;
                    first_q <= 1'b0;
                    if (idx_q == 5'd0) begin
                        result_q <= mac_acc;
                        status_q <= {31'd0, ovf_q | mac_ovf};
                        done_q   <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign n_rd_addr = sel_q;
    // Each set owns MAX_DEG+1 consecutive words; c_i sits at base + i.
    assign s_rd_addr = SADDR_W'(sel_q) * SET_STRIDE + SADDR_W'(idx_q);
    assign done      = done_q;
    assign result    = result_q;
    assign status    = status_q;

endmodule

// File: tb/tb_evp_horner_engine.sv
`timescale 1ns/1ps
module tb_evp_horner_engine;

  localparam int DATA_W   = 16;
  localparam int ACC_W    = 32;
  localparam int NUM_SETS = 8;
  localparam int MAX_DEG  = 10;
  localparam int SADDR_W  = 7;
  localparam int SEL_W    = 3;
  localparam int STRIDE   = MAX_DEG + 1;
  localparam longint ACC_MAX = (64'sd1 <<< 31) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< 31);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic               start;
  logic [SEL_W-1:0]   a_sel;
  logic [DATA_W-1:0]  x;
  logic               busy;
  logic               n_rd_en;
  logic [SEL_W-1:0]   n_rd_addr;
  logic [4:0]         n_rd_data;
  logic               s_rd_en;
  logic [SADDR_W-1:0] s_rd_addr;
  logic [DATA_W-1:0]  s_rd_data;
  logic               done;
  logic [ACC_W-1:0]   result;
  logic [31:0]        status;
  logic [2:0]         dbg_state;

  evp_horner_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_SETS(NUM_SETS),
    .MAX_DEG(MAX_DEG), .SADDR_W(SADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .a_sel(a_sel), .x(x),
    .busy(busy), .n_rd_en(n_rd_en), .n_rd_addr(n_rd_addr), .n_rd_data(n_rd_data),
    .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .done(done), .result(result), .status(status), .dbg_state(dbg_state)
  );

  // ---------------- memories (1-cycle synchronous read) ----------------
  logic [4:0]  n_mem [NUM_SETS];
  logic [15:0] s_mem [1 << SADDR_W];

  always @(posedge clk) begin
    if (n_rd_en) n_rd_data <= n_mem[n_rd_addr];
    if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit addr_chk_en = 1'b1;
  int last_exp_done = 0;

  logic [31:0] exp_res_q[$];
  logic [31:0] exp_st_q[$];
  logic [31:0] exp_cyc_q[$];
  logic [31:0] exp_n_q[$];
  logic [31:0] exp_s_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: Horner evaluation with ACC_W wrap after each step and
  // overflow judged by numeric range of the exact product and sum.
  task automatic model(input int sel, input logic [15:0] xv,
                       output logic [31:0] res, output logic [31:0] st,
                       output int lat, output int n, output bit is_err);
    longint acc, p, s, xs, c;
    logic signed [15:0] xs16, c16;
    logic signed [31:0] t;
    bit ovf;
    n = int'(n_mem[sel]);
    is_err = 1'b0;
    if (n == 31) begin
      res = 0; st = 2; lat = 3; is_err = 1'b1;
    end else if (n > MAX_DEG) begin
      res = 0; st = 3; lat = 3; is_err = 1'b1;
    end else begin
      xs16 = xv;
      xs = xs16;
      c16 = s_mem[sel * STRIDE + n];
      acc = c16;
      ovf = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        c16 = s_mem[sel * STRIDE + i];
        c = c16;
        p = acc * xs;
        s = p + c;
        if (p > ACC_MAX || p < ACC_MIN || s > ACC_MAX || s < ACC_MIN) ovf = 1'b1;
        t = s[31:0];
        acc = t;
      end
      res = acc[31:0];
      st = {31'd0, ovf};
      lat = 2 * n + 5;
    end
  endtask

  // Monitor: compares every read strobe and every done pulse against queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (n_rd_en && addr_chk_en) begin
        if (exp_n_q.size() == 0) note_fail("unexpected_n_read");
        else check("n_rd_addr", 64'(n_rd_addr), 64'(exp_n_q.pop_front()));
      end
      if (s_rd_en && addr_chk_en) begin
        if (exp_s_q.size() == 0) note_fail("unexpected_s_read");
        else check("s_rd_addr", 64'(s_rd_addr), 64'(exp_s_q.pop_front()));
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          note_fail("unexpected_done");
        end else begin
          check("result", 64'(result), 64'(exp_res_q.pop_front()));
          check("status", 64'(status), 64'(exp_st_q.pop_front()));
          check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) note_fail("busy_timeout");
  endtask

  task automatic issue(input logic [2:0] sel, input logic [15:0] xv, input bit expect_done);
    logic [31:0] res, st;
    int lat, n;
    bit is_err;
    model(int'(sel), xv, res, st, lat, n, is_err);
    if (expect_done) begin
      exp_n_q.push_back(32'(sel));
      if (!is_err)
        for (int i = n; i >= 0; i--) exp_s_q.push_back(32'(int'(sel) * STRIDE + i));
      exp_res_q.push_back(res);
      exp_st_q.push_back(st);
      exp_cyc_q.push_back(32'(cyc + lat));
      last_exp_done = cyc + lat;
    end
    start = 1'b1;
    a_sel = sel;
    x     = xv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_set(input int sel, input logic [4:0] n);
    n_mem[sel] = n;
    for (int i = 0; i < STRIDE; i++) s_mem[sel * STRIDE + i] = 16'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},      64'(busy), 64'd0);
    check({tag, "_done"},      64'(done), 64'd0);
    check({tag, "_n_rd_en"},   64'(n_rd_en), 64'd0);
    check({tag, "_s_rd_en"},   64'(s_rd_en), 64'd0);
    check({tag, "_n_rd_addr"}, 64'(n_rd_addr), 64'd0);
    check({tag, "_s_rd_addr"}, 64'(s_rd_addr), 64'd0);
    check({tag, "_result"},    64'(result), 64'd0);
    check({tag, "_status"},    64'(status), 64'hFFFF_FFFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v;
    int r;
    logic [4:0] nn;
    logic [15:0] xv;
    start = 1'b0;
    a_sel = '0;
    x     = '0;
    for (int i = 0; i < NUM_SETS; i++) n_mem[i] = 5'h1F;
    for (int i = 0; i < (1 << SADDR_W); i++) s_mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Set 2: N=2, c=[3,2,1], x=4
    wait_idle();
    n_mem[2] = 5'd2; s_mem[22] = 16'd3; s_mem[23] = 16'd2; s_mem[24] = 16'd1;
    issue(3'd2, 16'd4, 1'b1);

    // Set 0: N=0, c0=-5, x=7
    wait_idle();
    n_mem[0] = 5'd0; s_mem[0] = 16'hFFFB;
    issue(3'd0, 16'd7, 1'b1);

    // Set 1: unprogrammed, then degree out of range
    wait_idle();
    n_mem[1] = 5'h1F;
    issue(3'd1, 16'($urandom), 1'b1);
    wait_idle();
    n_mem[1] = 5'd11;
    issue(3'd1, 16'($urandom), 1'b1);

    // Overflow run followed by a clean run
    wait_idle();
    n_mem[4] = 5'd3;
    for (int i = 0; i < 4; i++) s_mem[44 + i] = 16'h7FFF;
    issue(3'd4, 16'h7FFF, 1'b1);
    wait_idle();
    n_mem[5] = 5'd1; s_mem[55] = 16'd1; s_mem[56] = 16'd1;
    issue(3'd5, 16'd1, 1'b1);

    // start with a_sel=3 during a busy run is ignored
    wait_idle();
    fill_set(6, 5'($urandom_range(1, MAX_DEG)));
    fill_set(3, 5'($urandom_range(0, MAX_DEG)));
    issue(3'd6, 16'($urandom), 1'b1);
    start = 1'b1; a_sel = 3'd3; x = 16'($urandom);
    repeat (3) @(negedge clk);
    start = 1'b0;

    // back-to-back: next request lands in the cycle after done
    wait_idle();
    check("b2b_idle_cycle", 64'(cyc), 64'(last_exp_done + 1));
    fill_set(2, 5'($urandom_range(0, MAX_DEG)));
    issue(3'd2, 16'($urandom_range(0, 6)) - 16'd3, 1'b1);

    // reset at cycle 5 of an N=4 run
    wait_idle();
    fill_set(7, 5'd4);
    addr_chk_en = 1'b0;
    issue(3'd7, 16'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    addr_chk_en = 1'b1;
    @(negedge clk);
    issue(3'd7, 16'($urandom_range(0, 6)) - 16'd3, 1'b1);

    // randomized runs
    for (int k = 0; k < 40; k++) begin
      wait_idle();
      v = $urandom_range(0, NUM_SETS - 1);
      r = $urandom_range(0, 13);
      if (r <= MAX_DEG) nn = 5'(r);
      else if (r == 11) nn = 5'($urandom_range(MAX_DEG + 1, 30));
      else if (r == 12) nn = 5'h1F;
      else nn = 5'($urandom_range(0, MAX_DEG));
      fill_set(v, nn);
      if ($urandom_range(0, 1) == 0) xv = 16'($urandom_range(0, 6)) - 16'd3;
      else xv = 16'($urandom);
      issue(3'(v), xv, 1'b1);
    end

    // drain
    wait_idle();
    begin
      int n = 0;
      while (exp_res_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(negedge clk);
    check("pending_done", 64'(exp_res_q.size()), 64'd0);
    check("pending_s_reads", 64'(exp_s_q.size()), 64'd0);
    check("pending_n_reads", 64'(exp_n_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
